// File: rtl/apple_sched.sv
// apple_sched: multi-apple sprite scheduler sharing one sprite ROM.
// Positions are double-buffered: commands land in a shadow set that is
// copied to the active set in a single commit cycle at vertical blanking.
// The pixel path picks the lowest-index active apple covering (col,row)
// and registers hit/select/ROM address one cycle after col/row.
module apple_sched #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int APPLE_W  = 22,
  parameter int APPLE_H  = 24,
  parameter int N_APPLES = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_id,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic        cmd_en,
  output logic        frame_tick,
  output logic [7:0]  frame_cnt,
  output logic        apple_hit,
  output logic [1:0]  apple_sel,
  output logic [10:0] apple_addr
);

  typedef enum logic [1:0] {BLANK, ACTIVE, COMMIT} state_t;

  localparam logic [9:0]  COMMIT_ROW = 10'(SCREEN_H);
  localparam logic [10:0] W_LIMIT    = 11'(SCREEN_W);
  localparam logic [10:0] H_LIMIT    = 11'(SCREEN_H);
  localparam logic [10:0] SPR_W      = 11'(APPLE_W);
  localparam logic [10:0] SPR_H      = 11'(APPLE_H);

  state_t      state_reg;
  logic [9:0]  row_q_reg;
  logic        cmd_ready_reg;
  logic        frame_tick_reg;
  logic [7:0]  frame_cnt_reg;
  logic        hit_reg;
  logic [1:0]  sel_reg;
  logic [10:0] addr_reg;

  logic        cmd_fire;
  logic [10:0] col_w;
  logic [10:0] row_w;
  logic        on_screen;

  logic [N_APPLES-1:0] hit_vec;
  logic [10:0]         addr_vec [N_APPLES];

  logic        win_hit;
  logic [1:0]  win_sel;
  logic [10:0] win_addr;

  assign cmd_fire  = cmd_valid && cmd_ready_reg;
  // Widen to 11 bits so x+APPLE_W near 1023 cannot wrap back on-screen.
  assign col_w     = {1'b0, col};
  assign row_w     = {1'b0, row};
  assign on_screen = (col_w < W_LIMIT) && (row_w < H_LIMIT);

  generate
    for (genvar gi = 0; gi < N_APPLES; gi++) begin : g_slot
      logic [9:0]  shadow_x_reg;
      logic [9:0]  shadow_y_reg;
      logic        shadow_en_reg;
      logic [9:0]  active_x_reg;
      logic [9:0]  active_y_reg;
      logic        active_en_reg;
      logic [10:0] ax;
      logic [10:0] ay;
      logic [10:0] dx;
      logic [10:0] dy;

      // Accepted command for this slot overwrites its shadow entry.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          shadow_x_reg  <= '0;
          shadow_y_reg  <= '0;
          shadow_en_reg <= 1'b0;
        end else if (cmd_fire && (cmd_id == 2'(gi))) begin
          shadow_x_reg  <= cmd_x;
          shadow_y_reg  <= cmd_y;
          shadow_en_reg <= cmd_en;
        end
      end

      // Shadow becomes active only at the end of the commit cycle.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          active_x_reg  <= '0;
          active_y_reg  <= '0;
          active_en_reg <= 1'b0;
        end else if (state_reg == COMMIT) begin
          active_x_reg  <= shadow_x_reg;
          active_y_reg  <= shadow_y_reg;
          active_en_reg <= shadow_en_reg;
        end
      end

      assign ax = {1'b0, active_x_reg};
      assign ay = {1'b0, active_y_reg};
      assign dx = col_w - ax;
      assign dy = row_w - ay;
      assign hit_vec[gi] = active_en_reg && on_screen &&
                           (col_w >= ax) && (col_w < ax + SPR_W) &&
                           (row_w >= ay) && (row_w < ay + SPR_H);
      assign addr_vec[gi] = dx + dy * SPR_W;
    end
  endgenerate

  // Lowest slot index wins; scan from the top so slot 0 is written last.
  always_comb begin
    win_hit  = 1'b0;
    win_sel  = '0;
    win_addr = '0;
    for (int i = N_APPLES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_hit  = 1'b1;
        win_sel  = 2'(i);
        win_addr = addr_vec[i];
      end
    end
  end

  // Frame FSM with registered ready/tick/count outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= BLANK;
      row_q_reg      <= '0;
      cmd_ready_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      row_q_reg      <= row;
      frame_tick_reg <= 1'b0;
      cmd_ready_reg  <= 1'b1;
      case (state_reg)
        BLANK: begin
          if (row == 10'd0) state_reg <= ACTIVE;
        end
        ACTIVE: begin
          if ((row == COMMIT_ROW) && (row_q_reg != COMMIT_ROW)) begin
            state_reg      <= COMMIT;
            frame_tick_reg <= 1'b1;
            frame_cnt_reg  <= frame_cnt_reg + 8'd1;
            cmd_ready_reg  <= 1'b0;
          end
        end
        COMMIT:  state_reg <= BLANK;
        default: state_reg <= BLANK;
      endcase
    end
  end

  // Register the winning apple: one cycle of latency from col/row.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hit_reg  <= 1'b0;
      sel_reg  <= '0;
      addr_reg <= '0;
    end else begin
      hit_reg  <= win_hit;
      sel_reg  <= win_sel;
      addr_reg <= win_addr;
    end
  end

  assign cmd_ready  = cmd_ready_reg;
  assign frame_tick = frame_tick_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign apple_hit  = hit_reg;
  assign apple_sel  = sel_reg;
  assign apple_addr = addr_reg;

endmodule

// File: tb/tb_apple_sched.sv
// Testbench for apple_sched: directed frames plus randomized commands and
// pixels, checked against a position-list reference model via a scoreboard.
module tb_apple_sched;
  localparam int N  = 4;
  localparam int SW = 800;
  localparam int SH = 600;
  localparam int AW = 22;
  localparam int AH = 24;

  logic        clk = 1'b0;
  logic        clrn;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_id;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic        cmd_en;
  logic        frame_tick;
  logic [7:0]  frame_cnt;
  logic        apple_hit;
  logic [1:0]  apple_sel;
  logic [10:0] apple_addr;

  always #5 clk = ~clk;

  apple_sched #(.N_APPLES(N)) dut (
    .clk(clk), .clrn(clrn), .col(col), .row(row),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_en(cmd_en),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt),
    .apple_hit(apple_hit), .apple_sel(apple_sel), .apple_addr(apple_addr)
  );

  typedef struct {
    logic        hit;
    logic [1:0]  sel;
    logic [10:0] addr;
    logic        tick;
    logic [7:0]  cnt;
    int          c;
    int          r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: two position lists plus frame bookkeeping.
  int sh_x[N], sh_y[N], act_x[N], act_y[N];
  bit sh_en[N], act_en[N];
  int m_cnt;
  bit in_frame, commit_pend, acc_pend, req_go;
  int prev_r;
  int req_id, req_x, req_y;
  bit req_en;

  task automatic chk(input string name, input int act, input int exp_v,
                     input int c, input int r);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s at col=%0d row=%0d: got %0d, expected %0d",
                  name, c, r, act, exp_v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0;
      act_x[i] = 0; act_y[i] = 0; act_en[i] = 0;
    end
    m_cnt = 0; in_frame = 0; commit_pend = 0; acc_pend = 0;
    req_go = 0; prev_r = 0;
  endtask

  // Highest-priority visible apple covering the pixel, plain integer math.
  function automatic exp_t model_pixel(input int c, input int r);
    exp_t e;
    e.hit = 0; e.sel = 0; e.addr = 0; e.tick = 0; e.cnt = 0; e.c = c; e.r = r;
    for (int i = 0; i < N; i++) begin
      if (!e.hit && act_en[i] && c < SW && r < SH &&
          c >= act_x[i] && c < act_x[i] + AW &&
          r >= act_y[i] && r < act_y[i] + AH) begin
        e.hit  = 1;
        e.sel  = 2'(i);
        e.addr = 11'((c - act_x[i]) + (r - act_y[i]) * AW);
      end
    end
    return e;
  endfunction

  task automatic send(input int id, input int x, input int y, input bit en);
    req_go = 1; req_id = id; req_x = x; req_y = y; req_en = en;
  endtask

  // One pixel clock: drive col/row (and any command), predict the result.
  task automatic step(input int c, input int r);
    exp_t e;
    bit commit_now, vb;
    @(negedge clk);
    commit_now  = commit_pend;
    commit_pend = 0;
    chk("cmd_ready", int'(cmd_ready), int'(!commit_now), c, r);
    if (acc_pend) begin cmd_valid = 1'b0; acc_pend = 0; end
    if (req_go) begin
      cmd_valid = 1'b1; cmd_id = 2'(req_id);
      cmd_x = 10'(req_x); cmd_y = 10'(req_y); cmd_en = req_en;
      req_go = 0;
    end
    col = 10'(c);
    row = 10'(r);
    if (cmd_valid && !commit_now) begin
      if (int'(cmd_id) < N) begin
        sh_x[cmd_id] = int'(cmd_x); sh_y[cmd_id] = int'(cmd_y);
        sh_en[cmd_id] = cmd_en;
      end
      acc_pend = 1;
      $display("cmd id=%0d x=%0d y=%0d en=%0d accepted at row=%0d",
               cmd_id, cmd_x, cmd_y, cmd_en, r);
    end
    vb = in_frame && r == SH && prev_r != SH;
    if (vb) begin
      in_frame = 0; commit_pend = 1; m_cnt++;
    end else if (!commit_now && !in_frame && r == 0) begin
      in_frame = 1;
    end
    e = model_pixel(c, r);
    e.tick = vb;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
    if (commit_now) begin
      for (int i = 0; i < N; i++) begin
        act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_en[i] = sh_en[i];
      end
    end
    prev_r = r;
  endtask

  task automatic begin_frame();
    step(0, 0);
  endtask

  task automatic end_frame();
    step(0, 600); step(1, 601); step(2, 602); step(3, 610);
  endtask

  task automatic rand_pix();
    int c, r, k;
    if ($urandom_range(0, 1) == 0) begin
      c = int'($urandom_range(0, 1023));
      r = int'($urandom_range(0, 1023));
    end else begin
      k = int'($urandom_range(0, N - 1));
      c = act_x[k] + int'($urandom_range(0, 27)) - 3;
      r = act_y[k] + int'($urandom_range(0, 29)) - 3;
    end
    if (c < 0) c = 0;
    if (c > 1023) c = 1023;
    if (r < 0) r = 0;
    if (r > 1023) r = 1023;
    if (r == SH) r = SH - 1;
    step(c, r);
  endtask

  task automatic rand_frame(input int n_pix, input bit with_cmds);
    int x, y;
    begin_frame();
    for (int i = 0; i < n_pix; i++) begin
      if (with_cmds && !req_go && !cmd_valid && $urandom_range(0, 9) == 0) begin
        x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(770, 1023))
                                         : int'($urandom_range(0, 790));
        y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(570, 1023))
                                         : int'($urandom_range(0, 590));
        send(int'($urandom_range(0, N - 1)), x, y, $urandom_range(0, 3) != 0);
      end
      rand_pix();
    end
    end_frame();
  endtask

  // Monitor: outputs are valid every cycle, one cycle after the pixel.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("apple_hit",  int'(apple_hit),  int'(mon_e.hit),  mon_e.c, mon_e.r);
      chk("apple_sel",  int'(apple_sel),  int'(mon_e.sel),  mon_e.c, mon_e.r);
      chk("apple_addr", int'(apple_addr), int'(mon_e.addr), mon_e.c, mon_e.r);
      chk("frame_tick", int'(frame_tick), int'(mon_e.tick), mon_e.c, mon_e.r);
      chk("frame_cnt",  int'(frame_cnt),  int'(mon_e.cnt),  mon_e.c, mon_e.r);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_x = '0; cmd_y = '0;
    cmd_en = 1'b0; col = '0; row = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hit",   int'(apple_hit),  0, 0, 0);
    chk("rst_sel",   int'(apple_sel),  0, 0, 0);
    chk("rst_addr",  int'(apple_addr), 0, 0, 0);
    chk("rst_tick",  int'(frame_tick), 0, 0, 0);
    chk("rst_cnt",   int'(frame_cnt),  0, 0, 0);
    chk("rst_ready", int'(cmd_ready),  0, 0, 0);
    clrn = 1'b1;

    // Empty frame: no hits anywhere, single tick at row 600.
    rand_frame(300, 0);

    // Mid-frame write is invisible until the following frame.
    begin_frame();
    step(50, 50); send(0, 100, 50, 1); step(60, 50);
    step(100, 50); step(121, 73);
    end_frame();
    begin_frame();
    step(100, 50); step(121, 73); step(122, 73);
    step(99, 50); step(100, 49); step(100, 74);
    end_frame();

    // Overlap: slot 0 beats slot 1.
    begin_frame(); send(1, 110, 60, 1); step(0, 1); step(0, 2); end_frame();
    begin_frame(); step(115, 65); step(110, 60); step(131, 83); end_frame();

    // Hide slot 0: slot 1 wins the same pixel.
    begin_frame(); send(0, 100, 50, 0); step(0, 1); step(0, 2); end_frame();
    begin_frame(); step(115, 65); step(100, 50); end_frame();

    // Edge clipping and no wrap near 1023.
    begin_frame();
    send(2, 790, 590, 1); step(0, 1); step(0, 2);
    send(3, 1015, 1010, 1); step(0, 3); step(0, 4);
    end_frame();
    begin_frame();
    step(799, 599); step(790, 590); step(789, 590); step(800, 595);
    for (int c = 0; c < 12; c++) step(c, 595);
    for (int r = 0; r < 14; r++) step(795, r);
    step(0, 0); step(5, 5); step(1023, 1015);
    end_frame();

    // Last write wins; command held across the commit cycle.
    begin_frame();
    send(0, 200, 200, 1); step(0, 1); send(0, 300, 300, 1); step(0, 2); step(0, 3);
    step(0, 600); send(3, 400, 400, 1); step(0, 601); step(0, 602); step(0, 603);
    begin_frame(); step(300, 300); step(200, 200); step(400, 400); end_frame();
    begin_frame(); step(400, 400); step(421, 423); end_frame();

    // Randomized commands and pixels.
    repeat (12) rand_frame(250, 1);

    // Asynchronous reset in the middle of a frame.
    begin_frame(); send(0, 100, 50, 1); step(0, 1); step(0, 2); end_frame();
    begin_frame(); step(5, 5); step(100, 50);
    @(posedge clk);
    #3;
    clrn = 1'b0;
    #1;
    chk("mid_rst_hit",   int'(apple_hit),  0, 100, 50);
    chk("mid_rst_sel",   int'(apple_sel),  0, 100, 50);
    chk("mid_rst_addr",  int'(apple_addr), 0, 100, 50);
    chk("mid_rst_cnt",   int'(frame_cnt),  0, 100, 50);
    chk("mid_rst_tick",  int'(frame_tick), 0, 100, 50);
    chk("mid_rst_ready", int'(cmd_ready),  0, 100, 50);
    cmd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    rand_frame(200, 1);
    rand_frame(200, 1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
